// File: rtl/answer_gen.sv
// answer_gen: secret-code generator for the 4-digit bulls-and-cows game.
// On req it draws four mutually distinct digits from a free-running 16-bit
// LFSR by rejection sampling. A draw budget (MAX_DRAWS) bounds the search;
// on exhaustion the code 0123 is presented with the fallback flag set.
// Optional build macro: ANSWER_HEX_EN (hex digits 0..F, 16-bit used mask).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for req; draw bookkeeping held clear
// DRAW   | one candidate evaluated per cycle, busy high
// DONE   | code complete (or fallback), valid high, waiting for req
module answer_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_DRAWS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        busy,
  output logic        valid,
  output logic [15:0] answer,
  output logic        fallback,
  output logic [6:0]  draws
);

`ifdef ANSWER_HEX_EN
  localparam int MASK_W = 16;
`else
  localparam int MASK_W = 10;
`endif

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [6:0]  DRAW_LIMIT = 7'(MAX_DRAWS);
  localparam logic [15:0] FALLBACK_CODE = 16'h0123;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [15:0]         lfsr;
  logic [MASK_W-1:0]   mask;
  logic [MASK_W-1:0]   cand_bit;
  logic [1:0]          idx;
  logic [15:0]         work;
  logic [15:0]         work_next;
  logic [3:0]          cand;
  logic                cand_ok;
  logic                accept;
  logic                last_accept;
  logic                out_of_budget;
  logic [6:0]          draws_inc;

  assign cand = lfsr[3:0];

`ifdef ANSWER_HEX_EN
  assign cand_ok = 1'b1;
`else
  assign cand_ok = (cand <= 4'd9);
`endif

  // LFSR free-runs in every state so request timing adds entropy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED_EFF;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Candidate evaluation: acceptance, completion and budget decisions
  always_comb begin
    cand_bit      = MASK_W'(1) << cand;
    accept        = cand_ok && ((mask & cand_bit) == '0);
    last_accept   = accept && (idx == 2'd0);
    draws_inc     = (draws == DRAW_LIMIT) ? draws : draws + 7'd1;
    // A 4th accept on the budget's last draw still counts as success.
    out_of_budget = (draws_inc == DRAW_LIMIT) && !last_accept;
    work_next     = work;
    if (accept) work_next[{idx, 2'b00} +: 4] = cand;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; req during DRAW is ignored
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req) state_next = S_DRAW;
      S_DRAW: if (last_accept || out_of_budget) state_next = S_DONE;
      S_DONE: if (req) state_next = S_DRAW;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs and draw bookkeeping; answer only changes on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      valid    <= 1'b0;
      answer   <= 16'h0000;
      fallback <= 1'b0;
      draws    <= 7'd0;
      mask     <= '0;
      idx      <= 2'd3;
      work     <= 16'h0000;
    end else begin
      busy  <= (state_next == S_DRAW);
      valid <= (state_next == S_DONE);
      case (state)
        S_DRAW: begin
          draws <= draws_inc;
          if (accept) begin
            work <= work_next;
            mask <= mask | cand_bit;
            idx  <= idx - 2'd1;
          end
          if (last_accept) begin
            answer   <= work_next;
            fallback <= 1'b0;
          end else if (out_of_budget) begin
            answer   <= FALLBACK_CODE;
            fallback <= 1'b1;
          end
        end
        default: begin
          if (state == S_IDLE || req) begin
            mask     <= '0;
            idx      <= 2'd3;
            draws    <= 7'd0;
            fallback <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_answer_gen.sv
// tb_answer_gen: scoreboard bench for answer_gen. Three instances cover the
// default configuration, a tiny draw budget (fallback) and a zero seed.
// Expected codes come from a bench-side LFSR/rejection model or hand constants.
module tb_answer_gen;

  localparam logic [15:0] SEED0 = 16'hACE1;
  localparam logic [15:0] SEED1 = 16'hFFFF;
  localparam logic [15:0] SEED2 = 16'h0000;
  localparam int MAXD0 = 64;
  localparam int MAXD1 = 4;
  localparam int MAXD2 = 64;
`ifdef ANSWER_HEX_EN
  localparam int DMAX = 15;
  localparam logic [15:0] FB_ANS  = 16'hEC80;
  localparam logic        FB_FLAG = 1'b0;
`else
  localparam int DMAX = 9;
  localparam logic [15:0] FB_ANS  = 16'h0123;
  localparam logic        FB_FLAG = 1'b1;
`endif

  typedef struct {
    int          id;
    logic [15:0] ans;
    logic        fb;
    int          nd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [3];
  logic        busy [3];
  logic        valid [3];
  logic        fallback [3];
  logic [15:0] answer [3];
  logic [6:0]  draws [3];
  logic [15:0] mdl [3];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  answer_gen #(.SEED(SEED0), .MAX_DRAWS(MAXD0)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .busy(busy[0]), .valid(valid[0]),
    .answer(answer[0]), .fallback(fallback[0]), .draws(draws[0]));
  answer_gen #(.SEED(SEED1), .MAX_DRAWS(MAXD1)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .busy(busy[1]), .valid(valid[1]),
    .answer(answer[1]), .fallback(fallback[1]), .draws(draws[1]));
  answer_gen #(.SEED(SEED2), .MAX_DRAWS(MAXD2)) u2 (
    .clk(clk), .rst(rst), .req(req[2]), .busy(busy[2]), .valid(valid[2]),
    .answer(answer[2]), .fallback(fallback[2]), .draws(draws[2]));

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSRs running alongside each instance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl[0] <= SEED0;
      mdl[1] <= SEED1;
      mdl[2] <= 16'h0001;
    end else begin
      for (int i = 0; i < 3; i++) mdl[i] <= lfsr_step(mdl[i]);
    end
  end

  // l0 is the LFSR value entering the edge where req is sampled
  function automatic exp_t predict(input int id, input logic [15:0] l0, input int maxd);
    exp_t        e;
    logic [15:0] l;
    logic [15:0] used;
    logic [15:0] code;
    int          cnt;
    int          c;
    l = lfsr_step(l0);
    used = '0;
    code = '0;
    cnt = 0;
    e.id = id;
    e.ans = 16'h0123;
    e.fb = 1'b1;
    e.nd = maxd;
    for (int n = 1; n <= maxd; n++) begin
      c = int'(l[3:0]);
      if (c <= DMAX && !used[c]) begin
        used[c] = 1'b1;
        code = {code[11:0], l[3:0]};
        cnt++;
        if (cnt == 4) begin
          e.ans = code;
          e.fb = 1'b0;
          e.nd = n;
          return e;
        end
      end
      l = lfsr_step(l);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance raises valid
  initial begin
    logic        pv [3];
    int          blen [3];
    exp_t        e;
    logic [15:0] a;
    logic        ok;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; blen[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          pv[i] = 1'b0;
          blen[i] = 0;
        end else begin
          if (busy[i]) blen[i]++;
          if (valid[i] && !pv[i]) begin
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_valid: inst %0d answer %0h with empty scoreboard", i, answer[i]);
            end else begin
              e = sb.pop_front();
              check("sb_instance", i, e.id);
              check("sb_answer", answer[i], e.ans);
              check("sb_fallback", fallback[i], e.fb);
              check("sb_draws", draws[i], e.nd);
              check("draws_vs_busy_len", draws[i], blen[i]);
              a = answer[i];
              ok = 1'b1;
              for (int x = 0; x < 4; x++) begin
                if (int'(a[x*4 +: 4]) > DMAX) ok = 1'b0;
                for (int y = x + 1; y < 4; y++)
                  if (a[x*4 +: 4] == a[y*4 +: 4]) ok = 1'b0;
              end
              check("digits_distinct_in_range", ok, 1'b1);
            end
            blen[i] = 0;
          end
          pv[i] = valid[i];
        end
      end
    end
  end

  // Issue a 1-cycle req at a negedge and queue its expected result
  task automatic issue(input int i, input exp_t e);
    sb.push_back(e);
    req[i] = 1'b1;
    @(negedge clk);
    req[i] = 1'b0;
    check("busy_after_req", busy[i], 1'b1);
    check("valid_after_req", valid[i], 1'b0);
  endtask

  task automatic wait_valid(input int i);
    int k;
    k = 0;
    while (!valid[i] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!valid[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: inst %0d valid not seen within 200 cycles", i);
    end
  endtask

  initial begin
    exp_t        e;
    exp_t        first0;
    longint      t_rel;
    longint      delta0;
    logic        saw_hex;
    logic [15:0] a;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", busy[i], 1'b0);
      check("rst_valid", valid[i], 1'b0);
      check("rst_answer", answer[i], 16'h0000);
      check("rst_fallback", fallback[i], 1'b0);
      check("rst_draws", draws[i], 7'd0);
    end
    check("rst_lfsr_seed", u0.lfsr, 16'hACE1);
    check("rst_lfsr_zero_seed", u2.lfsr, 16'h0001);
    rst = 1'b0;
    t_rel = $time;

    // Budget of 4 draws; candidates E,C,8,0 from seed FFFF
    e.id = 1; e.ans = FB_ANS; e.fb = FB_FLAG; e.nd = 4;
    issue(1, e);
    wait_valid(1);
    @(negedge clk);

    // Normal request on default instance
    delta0 = $time - t_rel;
    first0 = predict(0, mdl[0], MAXD0);
    issue(0, first0);
    wait_valid(0);
    @(negedge clk);

    // req from DONE restarts; a req two cycles into DRAW is ignored
    issue(0, predict(0, mdl[0], MAXD0));
    @(negedge clk);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    check("busy_during_ignored_req", busy[0], 1'b1);
    check("draws_counting", draws[0], 7'd2);
    wait_valid(0);
    @(negedge clk);

    // req held high: back-to-back codes, valid high for one cycle
    sb.push_back(predict(0, mdl[0], MAXD0));
    req[0] = 1'b1;
    @(negedge clk);
    check("b2b_busy_start", busy[0], 1'b1);
    wait_valid(0);
    sb.push_back(predict(0, mdl[0], MAXD0));
    @(negedge clk);
    check("b2b_valid_one_cycle", valid[0], 1'b0);
    check("b2b_busy_restart", busy[0], 1'b1);
    req[0] = 1'b0;
    wait_valid(0);
    @(negedge clk);

    // Reset in the second DRAW cycle aborts asynchronously
    issue(0, predict(0, mdl[0], MAXD0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy[0], 1'b0);
    check("abort_valid", valid[0], 1'b0);
    check("abort_answer", answer[0], 16'h0000);
    check("abort_draws", draws[0], 7'd0);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    t_rel = $time;
    repeat (int'(delta0 / 10)) @(negedge clk);
    issue(0, predict(0, mdl[0], MAXD0));
    wait_valid(0);
    check("repro_after_reset", answer[0], first0.ans);
    @(negedge clk);

    // Zero seed instance still completes
    issue(2, predict(2, mdl[2], MAXD2));
    wait_valid(2);
    @(negedge clk);

    // Many requests: all distinct-digit; hex build must show a digit >= A
    saw_hex = 1'b0;
    for (int r = 0; r < 200; r++) begin
      issue(0, predict(0, mdl[0], MAXD0));
      wait_valid(0);
      a = answer[0];
      for (int x = 0; x < 4; x++) if (a[x*4 +: 4] > 4'd9) saw_hex = 1'b1;
      @(negedge clk);
    end
`ifdef ANSWER_HEX_EN
    check("saw_hex_digit", saw_hex, 1'b1);
`else
    check("no_hex_digit", saw_hex, 1'b0);
`endif

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
